// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with ready handshakes.
// Optional CBNZ support is enabled by defining LEGV8_CBNZ_EN.
module legv8_multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_inc,
    output logic        pc_branch,
    output logic        reg2loc,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        illegal,
    output logic        instr_done,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE,
        C_LOAD,
        C_STORE,
        C_CBZ,
`ifdef LEGV8_CBNZ_EN
        C_CBNZ,
`endif
        C_B,
        C_ILL
    } cls_t;

    state_t cur, nxt;
    cls_t   cls, dec;

    always_comb begin
        casez (opcode)
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: dec = C_RTYPE;
            11'b11111000010: dec = C_LOAD;
            11'b11111000000: dec = C_STORE;
            11'b10110100???: dec = C_CBZ;
`ifdef LEGV8_CBNZ_EN
            11'b10110101???: dec = C_CBNZ;
`endif
            11'b000101?????: dec = C_B;
            default:         dec = C_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= S_FETCH;
            cls <= C_RTYPE;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE)
                cls <= dec;
        end
    end

    // reg2loc: 1 when Read Register 2 must be the Rt field
    function automatic logic rt_sel(input cls_t c);
        rt_sel = (c == C_STORE) || (c == C_CBZ)
`ifdef LEGV8_CBNZ_EN
              || (c == C_CBNZ)
`endif
              ;
    endfunction

    always_comb begin
        nxt        = cur;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_inc     = 1'b0;
        pc_branch  = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (cur)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_inc   = 1'b1;
                    nxt      = S_DECODE;
                end
            end
            S_DECODE: begin
                reg2loc = rt_sel(dec);
                if (dec == C_ILL) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                    nxt        = S_FETCH;
                end else begin
                    nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                reg2loc = rt_sel(cls);
                case (cls)
                    C_RTYPE: begin
                        alu_op = 2'b10;
                        nxt    = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        alu_src = 1'b1;
                        nxt     = S_MEM;
                    end
                    C_CBZ: begin
                        alu_op     = 2'b01;
                        pc_branch  = zero;
                        instr_done = 1'b1;
                        nxt        = S_FETCH;
                    end
`ifdef LEGV8_CBNZ_EN
                    C_CBNZ: begin
                        alu_op     = 2'b01;
                        pc_branch  = !zero;
                        instr_done = 1'b1;
                        nxt        = S_FETCH;
                    end
`endif
                    C_B: begin
                        pc_branch  = 1'b1;
                        instr_done = 1'b1;
                        nxt        = S_FETCH;
                    end
                    default: nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                reg2loc = rt_sel(cls);
                alu_src = 1'b1;
                if (cls == C_LOAD) begin
                    mem_read = 1'b1;
                    if (dmem_ready)
                        nxt = S_WB;
                end else begin
                    mem_write = 1'b1;
                    if (dmem_ready) begin
                        instr_done = 1'b1;
                        nxt        = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
                if (cls == C_LOAD) begin
                    mem_to_reg = 1'b1;
                    alu_src    = 1'b1;
                end else begin
                    alu_op = 2'b10;
                end
            end
            default: nxt = S_FETCH;
        endcase
        // reset wins over every strobe, including a stalled write
        if (reset) begin
            imem_req   = 1'b0;
            ir_write   = 1'b0;
            pc_inc     = 1'b0;
            pc_branch  = 1'b0;
            reg2loc    = 1'b0;
            alu_src    = 1'b0;
            alu_op     = 2'b00;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            illegal    = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign state = reset ? 3'd0 : cur;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Scoreboard testbench for legv8_multicycle_ctrl: per-cycle expected
// control vectors are queued with the stimulus and compared each cycle.
module tb_legv8_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, ir_write, pc_inc, pc_branch, reg2loc, alu_src;
    logic [1:0]  alu_op;
    logic        mem_read, mem_write, mem_to_reg, reg_write;
    logic        illegal, instr_done;
    logic [2:0]  state;

    legv8_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_inc(pc_inc),
        .pc_branch(pc_branch), .reg2loc(reg2loc), .alu_src(alu_src),
        .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal),
        .instr_done(instr_done), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [16:0] IMEM  = 17'h10000;
    localparam logic [16:0] IRW   = 17'h08000;
    localparam logic [16:0] PCI   = 17'h04000;
    localparam logic [16:0] PCB   = 17'h02000;
    localparam logic [16:0] R2L   = 17'h01000;
    localparam logic [16:0] ASRC  = 17'h00800;
    localparam logic [16:0] AOPR  = 17'h00400;
    localparam logic [16:0] AOPZ  = 17'h00200;
    localparam logic [16:0] MRD   = 17'h00100;
    localparam logic [16:0] MWR   = 17'h00080;
    localparam logic [16:0] M2R   = 17'h00040;
    localparam logic [16:0] RW    = 17'h00020;
    localparam logic [16:0] ILL   = 17'h00010;
    localparam logic [16:0] DONE  = 17'h00008;
    localparam logic [16:0] SF    = 17'd0;
    localparam logic [16:0] SD    = 17'd1;
    localparam logic [16:0] SE    = 17'd2;
    localparam logic [16:0] SM    = 17'd3;
    localparam logic [16:0] SW    = 17'd4;
    localparam logic [16:0] FETCHED = SF | IMEM | IRW | PCI;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] OP_B    = 11'b00010110011;
    localparam logic [10:0] OP_BAD  = 11'b11111111111;

    typedef struct packed {
        logic        rst;
        logic [10:0] op;
        logic        z;
        logic        ir;
        logic        dr;
    } stim_t;

    stim_t       stq[$];
    logic [16:0] sbq[$];
    int          checks = 0;
    int          fails  = 0;
    logic [16:0] obs, exp_v;

    assign obs = {imem_req, ir_write, pc_inc, pc_branch, reg2loc, alu_src,
                  alu_op, mem_read, mem_write, mem_to_reg, reg_write,
                  illegal, instr_done, state};

    task automatic add(input logic rst, input logic [10:0] op,
                       input logic z, input logic ir, input logic dr,
                       input logic [16:0] e);
        stim_t s;
        s.rst = rst; s.op = op; s.z = z; s.ir = ir; s.dr = dr;
        stq.push_back(s);
        sbq.push_back(e);
    endtask

    task automatic tick();
        stim_t s;
        s = stq.pop_front();
        @(posedge clk);
        #1;
        reset      = s.rst;
        opcode     = s.op;
        zero       = s.z;
        imem_ready = s.ir;
        dmem_ready = s.dr;
        @(negedge clk);
    endtask

    task automatic test_reset();
        add(1, OP_STUR, 1, 1, 1, '0);
        add(0, OP_ADD, 0, 0, 1, SF | IMEM);
        for (int i = 0; stq.size() > 0; i++) begin
            tick();
            exp_v = sbq.pop_front();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL reset c%0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_rtype();
        add(0, OP_ADD, 0, 1, 1, FETCHED);
        add(0, OP_ADD, 0, 1, 1, SD);
        add(0, OP_ADD, 0, 1, 1, SE | AOPR);
        add(0, OP_ADD, 0, 1, 1, SW | AOPR | RW | DONE);
        for (int i = 0; stq.size() > 0; i++) begin
            tick();
            exp_v = sbq.pop_front();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL add c%0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_load_stall();
        add(0, OP_LDUR, 0, 1, 1, FETCHED);
        add(0, OP_LDUR, 0, 1, 1, SD);
        add(0, OP_LDUR, 0, 1, 1, SE | ASRC);
        add(0, OP_LDUR, 0, 1, 0, SM | ASRC | MRD);
        add(0, OP_LDUR, 0, 1, 0, SM | ASRC | MRD);
        add(0, OP_LDUR, 0, 1, 1, SM | ASRC | MRD);
        add(0, OP_LDUR, 0, 1, 1, SW | ASRC | M2R | RW | DONE);
        for (int i = 0; stq.size() > 0; i++) begin
            tick();
            exp_v = sbq.pop_front();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL ldur c%0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_store();
        add(0, OP_STUR, 0, 0, 1, SF | IMEM);
        add(0, OP_STUR, 0, 1, 1, FETCHED);
        add(0, OP_STUR, 0, 1, 1, SD | R2L);
        add(0, OP_STUR, 0, 1, 1, SE | R2L | ASRC);
        add(0, OP_STUR, 0, 1, 1, SM | R2L | ASRC | MWR | DONE);
        for (int i = 0; stq.size() > 0; i++) begin
            tick();
            exp_v = sbq.pop_front();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL stur c%0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_cbz();
        add(0, OP_CBZ, 1, 1, 1, FETCHED);
        add(0, OP_CBZ, 1, 1, 1, SD | R2L);
        add(0, OP_CBZ, 1, 1, 1, SE | R2L | AOPZ | PCB | DONE);
        add(0, OP_CBZ, 0, 1, 1, FETCHED);
        add(0, OP_CBZ, 0, 1, 1, SD | R2L);
        add(0, OP_CBZ, 0, 1, 1, SE | R2L | AOPZ | DONE);
        for (int i = 0; stq.size() > 0; i++) begin
            tick();
            exp_v = sbq.pop_front();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL cbz c%0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_cbnz();
        add(0, OP_CBNZ, 0, 1, 1, FETCHED);
`ifdef LEGV8_CBNZ_EN
        add(0, OP_CBNZ, 0, 1, 1, SD | R2L);
        add(0, OP_CBNZ, 0, 1, 1, SE | R2L | AOPZ | PCB | DONE);
`else
        add(0, OP_CBNZ, 0, 1, 1, SD | ILL | DONE);
`endif
        for (int i = 0; stq.size() > 0; i++) begin
            tick();
            exp_v = sbq.pop_front();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL cbnz c%0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_branch();
        add(0, OP_B, 0, 1, 1, FETCHED);
        add(0, OP_B, 0, 1, 1, SD);
        add(0, OP_B, 0, 1, 1, SE | PCB | DONE);
        for (int i = 0; stq.size() > 0; i++) begin
            tick();
            exp_v = sbq.pop_front();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL b c%0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_illegal();
        add(0, OP_BAD, 0, 1, 1, FETCHED);
        add(0, OP_BAD, 0, 1, 1, SD | ILL | DONE);
        add(0, OP_BAD, 0, 0, 1, SF | IMEM);
        for (int i = 0; stq.size() > 0; i++) begin
            tick();
            exp_v = sbq.pop_front();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL illegal c%0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        add(0, OP_LDUR, 0, 1, 1, FETCHED);
        add(0, OP_LDUR, 0, 1, 1, SD);
        add(0, OP_LDUR, 0, 1, 1, SE | ASRC);
        add(0, OP_LDUR, 0, 1, 0, SM | ASRC | MRD);
        add(1, OP_LDUR, 0, 1, 0, '0);
        add(0, OP_LDUR, 0, 0, 1, SF | IMEM);
        add(0, OP_LDUR, 0, 0, 1, SF | IMEM);
        add(0, OP_ADD, 0, 1, 1, FETCHED);
        add(0, OP_ADD, 0, 1, 1, SD);
        for (int i = 0; stq.size() > 0; i++) begin
            tick();
            exp_v = sbq.pop_front();
            checks++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL rst_stall c%0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_stall();
        test_store();
        test_cbz();
        test_cbnz();
        test_branch();
        test_illegal();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/legv8_multicycle_ctrl.md
# legv8_multicycle_ctrl

Multi-cycle control sequencer for the LEGv8 datapath. Decodes the 11-bit opcode field of the instruction register and steps the shared ALU, register file, data memory and PC through FETCH/DECODE/EXEC/MEM/WB. It drives every datapath select and enable, including `reg2loc`, which steers the Read Register 2 mux. Memory accesses use a ready handshake, so variable-latency instruction and data memories stall the sequence cleanly.

## Interface
Parameters:
- none

Ports (name, direction, width, meaning):
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `opcode` input 11: Instruction[31:21] from the IR; valid from DECODE onward.
- `zero` input 1: ALU zero flag; sampled in EXEC.
- `imem_ready` input 1: instruction memory has data this cycle.
- `dmem_ready` input 1: data memory access completes this cycle.
- `imem_req` output 1: instruction fetch request.
- `ir_write` output 1: load the IR.
- `pc_inc` output 1: PC <= PC+4.
- `pc_branch` output 1: PC <= branch target.
- `reg2loc` output 1: 1 selects the Rt field Instruction[4:0] as Read Register 2; 0 selects Rm Instruction[20:16].
- `alu_src` output 1: 1 selects the sign-extended immediate.
- `alu_op` output 2: 00 add, 01 pass B (zero test), 10 R-type function.
- `mem_read` output 1: data memory read.
- `mem_write` output 1: data memory write.
- `mem_to_reg` output 1: write-back source is memory.
- `reg_write` output 1: register file write enable.
- `illegal` output 1: one-cycle pulse on an undecodable opcode.
- `instr_done` output 1: one-cycle pulse in the last cycle of each instruction.
- `state` output 3: current state encoding.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- Decoded classes:
  - RTYPE: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - LOAD: LDUR 11111000010.
  - STORE: STUR 11111000000.
  - CBZ: 10110100xxx.
  - CBNZ: 10110101xxx.
  - B: 000101xxxxx.
  - Anything else is ILLEGAL.
- FETCH:
  - `imem_req`=1 throughout.
  - Holds while `imem_ready`=0.
  - When `imem_ready`=1: `ir_write`=1, `pc_inc`=1, next state DECODE.
- DECODE:
  - The class is latched into an internal class register at the end of the cycle.
  - `reg2loc` is decoded combinationally from `opcode`: 1 for STORE, CBZ and CBNZ; otherwise 0.
  - ILLEGAL: `illegal`=1 and `instr_done`=1, next state FETCH.
  - Otherwise next state EXEC.
- EXEC:
  - RTYPE: `alu_op`=10; next WB.
  - LOAD/STORE: `alu_src`=1, `alu_op`=00; next MEM.
  - CBZ: `alu_op`=01; `pc_branch`=`zero`; `instr_done`=1; next FETCH.
  - CBNZ: `alu_op`=01; `pc_branch`=!`zero`; `instr_done`=1; next FETCH.
  - B: `pc_branch`=1, `instr_done`=1; next FETCH.
- MEM:
  - `alu_src`=1 and `alu_op`=00 are held.
  - LOAD: `mem_read`=1; advances to WB when `dmem_ready`=1.
  - STORE: `mem_write`=1; when `dmem_ready`=1, `instr_done`=1 and next FETCH.
  - Stays in MEM while `dmem_ready`=0; strobes stay asserted.
- WB:
  - `reg_write`=1 and `instr_done`=1; next FETCH.
  - RTYPE: `mem_to_reg`=0, `alu_op`=10.
  - LOAD: `mem_to_reg`=1, `alu_src`=1.
- From EXEC onward, `reg2loc` comes from the class register, so it stays stable for the whole instruction.
- Any output not listed for a state is 0 in that state.

## Timing
- Reset:
  - While `reset`=1, all outputs are combinationally forced to 0.
  - On the edge with `reset`=1: state <= FETCH and class <= RTYPE-clear (no-op).
  - First cycle after release: `state`=0, `imem_req`=1.
- Reset asserted mid-instruction, including a MEM stall, aborts the instruction. No write strobe is asserted in the reset cycle.
- Zero-wait latencies, FETCH through `instr_done`:
  - RTYPE 4 cycles, LOAD 5, STORE 4, CBZ/CBNZ/B 3, ILLEGAL 2.
- Each wait cycle on `imem_ready` or `dmem_ready` adds exactly one cycle.
- `pc_inc` and `pc_branch` are never high together.
- At most one of `mem_read`, `mem_write` and `reg_write` is high in any cycle.
- `ready` inputs are ignored outside their own state. A `dmem_ready` seen in FETCH has no effect.
- The cycle after `instr_done` is always FETCH.

## Configuration
- `LEGV8_CBNZ_EN`:
  - Defined: CBNZ is decoded as above.
  - Undefined: opcode 10110101xxx decodes as ILLEGAL (pulses `illegal`, 2-cycle no-op), and the CBNZ class logic is omitted.

## Test plan
- Reset, then ADD 10001011000 with `imem_ready`/`dmem_ready` tied to 1 -> `state` 0,1,2,4. `ir_write`/`pc_inc` high in cycle 0. `alu_op`=10 in cycles 2–3. `reg_write`=1 and `instr_done`=1 in cycle 3. `reg2loc`=0 throughout.
- LDUR with `dmem_ready` low for 2 cycles in MEM -> `state` 0,1,2,3,3,3,4. `mem_read`=1 for all 3 MEM cycles. WB has `mem_to_reg`=1 and `reg_write`=1. Total 7 cycles.
- STUR -> `reg2loc`=1 from DECODE through MEM. `mem_write`=1 in MEM only. `reg_write` never high. `instr_done` in MEM.
- CBZ with `zero`=1, then CBZ with `zero`=0 -> `pc_branch`=1 in EXEC for the first, 0 for the second. Both complete in 3 cycles with `reg2loc`=1. With `LEGV8_CBNZ_EN` defined, CBNZ with `zero`=0 -> `pc_branch`=1.
- Opcode 11111111111 -> `illegal`=1 for one cycle in DECODE, then FETCH. Without `LEGV8_CBNZ_EN`, opcode 10110101000 gives the same response.
- Assert `reset` during a LDUR MEM stall -> all outputs 0 that cycle. `state`=0 and `imem_req`=1 on the first cycle after release.
